cbuf_acq_seq: RTL and testbench

- Per-channel circular-buffer (CBUF) readout sequencer that sits directly upstream of the CBUF ADC data mux.
- On each accepted trigger it drives the mux selects and `checksum_update` to emit one fill: fill header, waveform header, `N` data bursts, then checksum.
- It issues reads to the circular-buffer RAM and generates the DDR3 write-FIFO write enable aligned with the mux's registered output.
- It maintains the fill number.

---
 rtl/cbuf_acq_seq_pkg.sv | 20 ++
 rtl/cbuf_acq_seq.sv | 154 +++++++++++++++
 tb/tb_cbuf_acq_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cbuf_acq_seq_pkg.sv
// Shared definitions for the circular-buffer readout sequencer.
package cbuf_acq_seq_pkg;

    // One circular-buffer word holds this many ADC pairs (8 samples, 128 bits).
    localparam int CBUF_WORD_PAIRS = 4;

    // Shift that converts a pre-trigger count in ADC pairs into buffer words.
    localparam int PAIR_SHIFT = $clog2(CBUF_WORD_PAIRS);

    typedef enum logic [2:0] {
        IDLE,
        FILL_HDR,
        WFM_HDR,
        DATA,
        DRAIN,
        CKSUM,
        DONE
    } state_t;

endpackage

// File: rtl/cbuf_acq_seq.sv
// CBUF readout sequencer: drives the ADC data mux selects, the circular-buffer
// reads and the DDR3 write-FIFO write enable for one fill per accepted trigger.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for an enabled trigger
// FILL_HDR | emit the fill header word once the FIFO has room
// WFM_HDR  | emit the waveform header word once the FIFO has room
// DATA     | one buffer read per cycle the FIFO has room, until bursts done
// DRAIN    | let the last data word reach the checksum accumulator
// CKSUM    | emit the checksum word once the FIFO has room
// DONE     | pulse fill_done and advance the fill number
module cbuf_acq_seq
    import cbuf_acq_seq_pkg::*;
#(
    parameter int ADR_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acq_trig,
    input  logic [1:0]       fill_type,
    input  logic [13:0]      async_num_bursts,
    input  logic [15:0]      async_pre_trig,
    input  logic [ADR_W-1:0] trig_ptr,
    input  logic             fifo_almost_full,
    output logic             cbuf_rd_en,
    output logic [ADR_W-1:0] cbuf_rd_adr,
    output logic             select_fill_hdr,
    output logic             select_waveform_hdr,
    output logic             select_dat,
    output logic             select_checksum,
    output logic             checksum_update,
    output logic             fifo_wr_en,
    output logic [23:0]      fill_num,
    output logic             busy,
    output logic             fill_done,
    output logic             trig_ignored
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [ADR_W-1:0] adr;
    logic [13:0]      burst_cnt;
    logic             dat_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the header/checksum selects and read strobe.
    always_comb begin
        state_nxt           = state;
        accept              = 1'b0;
        cbuf_rd_en          = 1'b0;
        select_fill_hdr     = 1'b0;
        select_waveform_hdr = 1'b0;
        select_checksum     = 1'b0;
        case (state)
            IDLE: begin
                if (acq_trig && (fill_type != 2'd0)) begin
                    accept    = 1'b1;
                    state_nxt = FILL_HDR;
                end
            end
            FILL_HDR: begin
                if (!fifo_almost_full) begin
                    select_fill_hdr = 1'b1;
                    state_nxt       = WFM_HDR;
                end
            end
            WFM_HDR: begin
                if (!fifo_almost_full) begin
                    select_waveform_hdr = 1'b1;
                    state_nxt           = (burst_cnt == 14'd0) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (!fifo_almost_full) begin
                    cbuf_rd_en = 1'b1;
                    if (burst_cnt == 14'd1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = CKSUM;
            end
            CKSUM: begin
                if (!fifo_almost_full) begin
                    select_checksum = 1'b1;
                    state_nxt       = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read address and remaining-burst counters; start address backs off the
    // pre-trigger depth from the write pointer, wrapping around the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr       <= '0;
            burst_cnt <= '0;
        end else if (accept) begin
            adr       <= trig_ptr - ADR_W'(async_pre_trig >> PAIR_SHIFT);
            burst_cnt <= async_num_bursts;
        end else if (cbuf_rd_en) begin
            adr       <= adr + 1'b1;
            burst_cnt <= burst_cnt - 14'd1;
        end
    end

    // Data pipeline aligned to the RAM read latency, FIFO write enable aligned
    // to the mux's registered output, and the status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q        <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fill_done    <= 1'b0;
            trig_ignored <= 1'b0;
        end else begin
            dat_q        <= cbuf_rd_en;
            fifo_wr_en   <= select_fill_hdr | select_waveform_hdr | dat_q | select_checksum;
            fill_done    <= select_checksum;
            trig_ignored <= acq_trig & ~accept;
        end
    end

    // Fill counter advances only when a fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_num <= '0;
        end else if (state == DONE) begin
            fill_num <= fill_num + 24'd1;
        end
    end

    assign select_dat      = dat_q;
    assign checksum_update = dat_q;
    assign cbuf_rd_adr     = adr;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_cbuf_acq_seq.sv
// Scoreboard bench for cbuf_acq_seq: stimulus pushes the expected word order,
// read addresses and word counts; a negedge monitor pops and compares.
module tb_cbuf_acq_seq;

    localparam int ADR_W = 12;
    localparam int DEPTH = 1 << ADR_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             acq_trig = 1'b0;
    logic [1:0]       fill_type = 2'd0;
    logic [13:0]      async_num_bursts = '0;
    logic [15:0]      async_pre_trig = '0;
    logic [ADR_W-1:0] trig_ptr = '0;
    logic             fifo_almost_full = 1'b0;
    logic             cbuf_rd_en;
    logic [ADR_W-1:0] cbuf_rd_adr;
    logic             select_fill_hdr;
    logic             select_waveform_hdr;
    logic             select_dat;
    logic             select_checksum;
    logic             checksum_update;
    logic             fifo_wr_en;
    logic [23:0]      fill_num;
    logic             busy;
    logic             fill_done;
    logic             trig_ignored;

    cbuf_acq_seq #(.ADR_W(ADR_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .acq_trig            (acq_trig),
        .fill_type           (fill_type),
        .async_num_bursts    (async_num_bursts),
        .async_pre_trig      (async_pre_trig),
        .trig_ptr            (trig_ptr),
        .fifo_almost_full    (fifo_almost_full),
        .cbuf_rd_en          (cbuf_rd_en),
        .cbuf_rd_adr         (cbuf_rd_adr),
        .select_fill_hdr     (select_fill_hdr),
        .select_waveform_hdr (select_waveform_hdr),
        .select_dat          (select_dat),
        .select_checksum     (select_checksum),
        .checksum_update     (checksum_update),
        .fifo_wr_en          (fifo_wr_en),
        .fill_num            (fill_num),
        .busy                (busy),
        .fill_done           (fill_done),
        .trig_ignored        (trig_ignored)
    );

    always #5 clk = ~clk;

    // Word codes of the fill stream: 1 fill hdr, 2 wfm hdr, 3 data, 4 checksum.
    int ev_q[$];
    int addr_q[$];
    int words_q[$];
    int model_fill = 0;
    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(bit ok, string name, int act, int exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference fill: header, waveform header, one data word per burst read
    // from consecutive buffer words starting pre_trig/4 words before the pointer.
    function automatic void push_fill(int nb, int pre, int ptr);
        int start;
        start = (((ptr - pre / 4) % DEPTH) + DEPTH) % DEPTH;
        ev_q.push_back(1);
        ev_q.push_back(2);
        for (int i = 0; i < nb; i++) begin
            ev_q.push_back(3);
            addr_q.push_back((start + i) % DEPTH);
        end
        ev_q.push_back(4);
        words_q.push_back(nb + 3);
    endfunction

    // Monitor.
    int  m_nsel;
    int  m_code;
    int  m_exp;
    int  m_wr_cnt = 0;
    bit  m_prev_any = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_prev_any = 1'b0;
            m_wr_cnt   = 0;
        end else begin
            m_nsel = int'(select_fill_hdr) + int'(select_waveform_hdr)
                   + int'(select_dat) + int'(select_checksum);
            chk(m_nsel <= 1, "sel_onehot", m_nsel, 1);
            chk(fifo_wr_en == m_prev_any, "wr_align", int'(fifo_wr_en), int'(m_prev_any));
            chk(checksum_update == select_dat, "cksum_update", int'(checksum_update), int'(select_dat));
            chk(!(cbuf_rd_en && fifo_almost_full), "rd_while_af", int'(cbuf_rd_en), 0);
            if (cbuf_rd_en) begin
                if (addr_q.size() == 0) begin
                    chk(1'b0, "rd_unexpected", int'(cbuf_rd_adr), -1);
                end else begin
                    m_exp = addr_q.pop_front();
                    chk(int'(cbuf_rd_adr) == m_exp, "rd_adr", int'(cbuf_rd_adr), m_exp);
                end
            end
            if (m_nsel != 0) begin
                m_code = select_fill_hdr ? 1 : select_waveform_hdr ? 2 : select_dat ? 3 : 4;
                if (ev_q.size() == 0) begin
                    chk(1'b0, "sel_unexpected", m_code, 0);
                end else begin
                    m_exp = ev_q.pop_front();
                    chk(m_code == m_exp, "sel_order", m_code, m_exp);
                end
            end
            if (fifo_wr_en) m_wr_cnt++;
            if (fill_done) begin
                if (words_q.size() == 0) begin
                    chk(1'b0, "done_unexpected", m_wr_cnt, 0);
                end else begin
                    m_exp = words_q.pop_front();
                    chk(m_wr_cnt == m_exp, "wr_count", m_wr_cnt, m_exp);
                end
                chk(int'(fill_num) == model_fill, "fill_num", int'(fill_num), model_fill);
                model_fill = (model_fill + 1) % (1 << 24);
                m_wr_cnt   = 0;
            end
            m_prev_any = (m_nsel != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk(!busy, "idle_timeout", int'(busy), 0);
    endtask

    task automatic start_fill(int nb, int pre, int ptr);
        wait_idle();
        acq_trig         = 1'b1;
        fill_type        = 2'($urandom_range(1, 3));
        async_num_bursts = 14'(nb);
        async_pre_trig   = 16'(pre);
        trig_ptr         = ADR_W'(ptr);
        push_fill(nb, pre, ptr);
        tick();
        acq_trig         = 1'b0;
        async_num_bursts = 14'($urandom);
        async_pre_trig   = 16'($urandom);
        trig_ptr         = ADR_W'($urandom);
        chk(busy, "busy_after_accept", int'(busy), 1);
        chk(!trig_ignored, "no_ignore_on_accept", int'(trig_ignored), 0);
    endtask

    // bp: 0 none, 1 random, 2 held high for 10 cycles inside DATA.
    task automatic run_fill(int bp, bit inject);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (bp == 1) fifo_almost_full = ($urandom_range(0, 3) == 0);
            else if (bp == 2) fifo_almost_full = (i >= 3 && i < 13);
            else fifo_almost_full = 1'b0;
            if (inject) begin
                acq_trig  = (i == 5);
                fill_type = 2'd1;
                if (i == 6) chk(trig_ignored, "ignore_busy", int'(trig_ignored), 1);
            end
            @(negedge clk);
            done = fill_done;
            tick();
        end
        acq_trig         = 1'b0;
        fifo_almost_full = 1'b0;
        chk(done, "fill_timeout", int'(done), 1);
    endtask

    initial begin
        repeat (3) tick();
        chk(!busy && !cbuf_rd_en && !fifo_wr_en && !fill_done && !trig_ignored,
            "reset_outputs", int'(busy), 0);
        chk(fill_num == 24'd0, "reset_fill_num", int'(fill_num), 0);
        rst = 1'b0;
        tick();

        start_fill(4, 8, 100);     run_fill(0, 1'b0);
        start_fill(5, 12, 1);      run_fill(0, 1'b0);
        start_fill(0, $urandom_range(0, 65535), $urandom_range(0, DEPTH - 1));
        run_fill(0, 1'b0);
        start_fill(16, $urandom_range(0, 65535), $urandom_range(0, DEPTH - 1));
        run_fill(2, 1'b0);
        start_fill(12, 40, 7);     run_fill(0, 1'b1);

        wait_idle();
        acq_trig  = 1'b1;
        fill_type = 2'd0;
        tick();
        acq_trig  = 1'b0;
        chk(trig_ignored, "ignore_disabled", int'(trig_ignored), 1);
        chk(!busy, "stay_idle", int'(busy), 0);
        tick();
        chk(!trig_ignored, "ignore_single_pulse", int'(trig_ignored), 0);

        start_fill(20, 0, 50);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk(!cbuf_rd_en && !select_dat && !select_fill_hdr && !select_waveform_hdr
            && !select_checksum && !fifo_wr_en && !busy && !fill_done,
            "abort_outputs", int'(busy), 0);
        chk(int'(fill_num) == 0, "abort_fill_num", int'(fill_num), 0);
        ev_q.delete();
        addr_q.delete();
        words_q.delete();
        model_fill = 0;
        tick();
        rst = 1'b0;
        tick();
        start_fill(6, 20, 4000);   run_fill(0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            start_fill($urandom_range(0, 40), $urandom_range(0, 65535),
                       $urandom_range(0, DEPTH - 1));
            run_fill(1, 1'b0);
        end

        repeat (3) tick();
        chk(ev_q.size() == 0, "ev_q_empty", ev_q.size(), 0);
        chk(addr_q.size() == 0, "addr_q_empty", addr_q.size(), 0);
        chk(int'(fill_num) == model_fill, "final_fill_num", int'(fill_num), model_fill);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
